// File: rtl/avalon_addsub_pkg.sv
// Shared definitions for the Avalon-MM add/subtract unit: register map,
// CTRL/STATUS bit positions and the sequencing FSM states.
package avalon_addsub_pkg;

  localparam logic [2:0] ADDR_OPA    = 3'd0;
  localparam logic [2:0] ADDR_OPB    = 3'd1;
  localparam logic [2:0] ADDR_CTRL   = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;
  localparam logic [2:0] ADDR_RESULT = 3'd4;
  localparam logic [2:0] ADDR_ID     = 3'd5;

  localparam int CTRL_START  = 0;
  localparam int CTRL_SUB    = 1;
  localparam int CTRL_ACC    = 2;
  localparam int CTRL_IRQ_EN = 3;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_DONE  = 1;
  localparam int STAT_CARRY = 2;
  localparam int STAT_OVF   = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/addsub_pipe.sv
// Add/subtract datapath: the operation is evaluated as operands are captured,
// then the result (with carry and signed overflow) travels through STAGES registers.
module addsub_pipe #(
  parameter int DATA_W = 32,
  parameter int STAGES = 2
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  output logic              out_valid,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              ovf
);

  // Handshake: in_valid is a one-cycle pulse that samples a/b/sub on that edge;
  // out_valid pulses exactly STAGES-1 cycles after the sampling edge with the
  // matching result. There is no back-pressure, so no ready signal exists.
  logic [DATA_W:0] wide;
  logic            ovf_now;

  always_comb begin
    if (sub) begin
      wide    = {1'b0, a} - {1'b0, b};
      ovf_now = (a[DATA_W-1] != b[DATA_W-1]) && (wide[DATA_W-1] != a[DATA_W-1]);
    end else begin
      wide    = {1'b0, a} + {1'b0, b};
      ovf_now = (a[DATA_W-1] == b[DATA_W-1]) && (wide[DATA_W-1] != a[DATA_W-1]);
    end
  end

  logic [STAGES-1:0] vld;
  logic [DATA_W+1:0] data [STAGES];

  always_ff @(posedge clock) begin
    if (!resetn) begin
      vld <= '0;
      for (int i = 0; i < STAGES; i++) data[i] <= '0;
    end else begin
      vld[0]  <= in_valid;
      data[0] <= {ovf_now, wide};
      for (int i = 1; i < STAGES; i++) begin
        vld[i]  <= vld[i-1];
        data[i] <= data[i-1];
      end
    end
  end

  assign out_valid              = vld[STAGES-1];
  assign {ovf, carry, result}   = data[STAGES-1];

endmodule

// File: rtl/avalon_addsub_unit.sv
// Avalon-MM slave wrapping the add/subtract pipeline: register file, bus
// decode, done/irq bookkeeping and the IDLE/RUN/DONE sequencer.
module avalon_addsub_unit
  import avalon_addsub_pkg::*;
#(
  parameter int          DATA_W   = 32,
  parameter int          STAGES   = 2,
  parameter logic [31:0] ID_VALUE = 32'h12345678
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [2:0]        address,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  input  logic              read,
  output logic [DATA_W-1:0] readdata,
  output logic              irq,
  output state_t            debug_state
);

  logic [DATA_W-1:0] opa, opb, result;
  logic              sub_q, acc_q, irq_en;
  logic              done, carry, ovf;
  state_t            state;

  logic busy, wr_ok, start, rd_result;
  assign busy      = (state == ST_RUN);
  assign wr_ok     = write && !busy;
  assign start     = wr_ok && (address == ADDR_CTRL) && writedata[CTRL_START];
  assign rd_result = read && (address == ADDR_RESULT);

  // Operation mode comes straight from the CTRL write that starts it.
  logic [DATA_W-1:0] pipe_a;
  logic              pipe_valid, pipe_carry, pipe_ovf;
  logic [DATA_W-1:0] pipe_result;
  assign pipe_a = writedata[CTRL_ACC] ? result : opa;

  addsub_pipe #(
    .DATA_W (DATA_W),
    .STAGES (STAGES)
  ) u_pipe (
    .clock     (clock),
    .resetn    (resetn),
    .in_valid  (start),
    .a         (pipe_a),
    .b         (opb),
    .sub       (writedata[CTRL_SUB]),
    .out_valid (pipe_valid),
    .result    (pipe_result),
    .carry     (pipe_carry),
    .ovf       (pipe_ovf)
  );

  logic [3:0]        ctrl_rd, status_rd;
  logic [DATA_W-1:0] rd_mux;

  always_comb begin
    ctrl_rd              = '0;
    ctrl_rd[CTRL_SUB]    = sub_q;
    ctrl_rd[CTRL_ACC]    = acc_q;
    ctrl_rd[CTRL_IRQ_EN] = irq_en;
    status_rd             = '0;
    status_rd[STAT_BUSY]  = busy;
    status_rd[STAT_DONE]  = done;
    status_rd[STAT_CARRY] = carry;
    status_rd[STAT_OVF]   = ovf;
    case (address)
      ADDR_OPA:    rd_mux = opa;
      ADDR_OPB:    rd_mux = opb;
      ADDR_CTRL:   rd_mux = DATA_W'(ctrl_rd);
      ADDR_STATUS: rd_mux = DATA_W'(status_rd);
      ADDR_RESULT: rd_mux = result;
      ADDR_ID:     rd_mux = DATA_W'(ID_VALUE);
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      opa      <= '0;
      opb      <= '0;
      sub_q    <= 1'b0;
      acc_q    <= 1'b0;
      irq_en   <= 1'b0;
      result   <= '0;
      carry    <= 1'b0;
      ovf      <= 1'b0;
      done     <= 1'b0;
      readdata <= '0;
    end else begin
      if (wr_ok) begin
        case (address)
          ADDR_OPA:  opa <= writedata;
          ADDR_OPB:  opb <= writedata;
          ADDR_CTRL: begin
            sub_q  <= writedata[CTRL_SUB];
            acc_q  <= writedata[CTRL_ACC];
            irq_en <= writedata[CTRL_IRQ_EN];
          end
          default: ;
        endcase
      end
      if (pipe_valid) begin
        result <= pipe_result;
        carry  <= pipe_carry;
        ovf    <= pipe_ovf;
      end
      // A completion landing on the same edge as a RESULT read keeps done set.
      if (pipe_valid)              done <= 1'b1;
      else if (start || rd_result) done <= 1'b0;
      if (read) readdata <= rd_mux;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: if (start) state <= ST_RUN;
        ST_RUN:           if (pipe_valid) state <= ST_DONE;
        default:          state <= ST_IDLE;
      endcase
    end
  end

  assign irq         = done && irq_en;
  assign debug_state = state;

endmodule

// File: tb/tb_avalon_addsub_unit.sv
// Self-checking bench: directed register-level scenarios with literal results,
// then random bus traffic, all compared each cycle against a behavioural model.
module tb_avalon_addsub_unit;
  import avalon_addsub_pkg::*;

  localparam int DATA_W = 32;
  localparam int STAGES = 2;

  // ---------------- clock / reset / DUT ----------------
  logic              clock = 1'b0;
  logic              resetn;
  logic [2:0]        address;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              read;
  logic [DATA_W-1:0] readdata;
  logic              irq;
  state_t            debug_state;

  always #5 clock = ~clock;

  avalon_addsub_unit #(
    .DATA_W   (DATA_W),
    .STAGES   (STAGES),
    .ID_VALUE (32'h12345678)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .address     (address),
    .write       (write),
    .writedata   (writedata),
    .read        (read),
    .readdata    (readdata),
    .irq         (irq),
    .debug_state (debug_state)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- behavioural model ----------------
  int          cyc = 0;
  logic [31:0] m_opa, m_opb, m_result, m_rdata;
  logic        m_sub, m_acc, m_irq_en, m_done, m_carry, m_ovf, m_irq;
  logic        m_pend;
  int          m_pend_cyc;
  logic [31:0] p_result;
  logic        p_carry, p_ovf;

  task automatic model_clear();
    m_opa = 0; m_opb = 0; m_result = 0; m_rdata = 0;
    m_sub = 0; m_acc = 0; m_irq_en = 0; m_done = 0; m_carry = 0; m_ovf = 0;
    m_irq = 0; m_pend = 0; m_pend_cyc = 0;
  endtask

  // Evaluated just before each rising edge from the inputs about to be sampled.
  task automatic model_step();
    logic [31:0] a, b, rd, res;
    logic        busy_now, compl, wr_ok, start, c, o;
    longint      sa, sb, ex, lim;
    longint unsigned us;
    cyc++;
    if (!resetn) begin
      model_clear();
      return;
    end
    busy_now = m_pend;
    compl    = m_pend && (cyc == m_pend_cyc);
    case (address)
      3'd0: rd = m_opa;
      3'd1: rd = m_opb;
      3'd2: rd = {28'b0, m_irq_en, m_acc, m_sub, 1'b0};
      3'd3: rd = {28'b0, m_ovf, m_carry, m_done, busy_now};
      3'd4: rd = m_result;
      3'd5: rd = 32'h12345678;
      default: rd = 32'h0;
    endcase
    if (read) m_rdata = rd;
    wr_ok = write && !busy_now;
    start = wr_ok && (address == 3'd2) && writedata[0];
    if (start) begin
      a   = writedata[2] ? m_result : m_opa;
      b   = m_opb;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      lim = 64'sh7FFFFFFF;
      if (writedata[1]) begin
        res = a - b;
        c   = (a < b);
        ex  = sa - sb;
      end else begin
        us  = 64'(a) + 64'(b);
        res = a + b;
        c   = us[32];
        ex  = sa + sb;
      end
      o = (ex > lim) || (ex < -lim - 1);
    end
    if (compl) begin
      m_result = p_result; m_carry = p_carry; m_ovf = p_ovf;
      m_done = 1; m_pend = 0;
    end
    if (wr_ok) begin
      case (address)
        3'd0: m_opa = writedata;
        3'd1: m_opb = writedata;
        3'd2: begin
          m_sub = writedata[1]; m_acc = writedata[2]; m_irq_en = writedata[3];
        end
        default: ;
      endcase
    end
    if (start) begin
      p_result = res; p_carry = c; p_ovf = o;
      m_pend = 1; m_pend_cyc = cyc + STAGES; m_done = 0;
    end else if (!compl && read && address == 3'd4) begin
      m_done = 0;
    end
    m_irq = m_done && m_irq_en;
  endtask

  // ---------------- scoreboard / checks ----------------
  task automatic check(input string name, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One clock: model sees current inputs, then outputs are compared after the edge.
  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    check("readdata", readdata, m_rdata);
    check("irq", DATA_W'(irq), DATA_W'(m_irq));
    check("busy", DATA_W'(debug_state == ST_RUN), DATA_W'(m_pend));
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_write(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    tick();
    write = 1'b0;
  endtask

  task automatic do_read(input logic [2:0] a, output logic [31:0] d);
    address = a; read = 1'b1;
    tick();
    read = 1'b0;
    d = readdata;
  endtask

  task automatic do_rw(input logic [2:0] a, input logic [31:0] wd, output logic [31:0] d);
    address = a; writedata = wd; read = 1'b1; write = 1'b1;
    tick();
    read = 1'b0; write = 1'b0;
    d = readdata;
  endtask

  task automatic wait_done(input string name, input logic [31:0] exp_status);
    logic [31:0] s;
    logic        seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      do_read(ADDR_STATUS, s);
      if (s[STAT_DONE]) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
    check({name, "_status"}, s, exp_status);
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ctrl, input logic [31:0] exp_status,
                        input logic [31:0] exp_result);
    logic [31:0] r;
    do_write(ADDR_OPA, a);
    do_write(ADDR_OPB, b);
    do_write(ADDR_CTRL, ctrl);
    wait_done(name, exp_status);
    do_read(ADDR_RESULT, r);
    check({name, "_result"}, r, exp_result);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h7FFFFFFF;
      3: return 32'h80000000;
      4: return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] r;
    int          n;
    model_clear();
    resetn = 1'b0; address = '0; write = 1'b0; writedata = '0; read = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    tick();

    // Reset values and ID / unmapped addresses
    for (int i = 0; i < 5; i++) begin
      do_read(3'(i), r);
      check($sformatf("reset_reg%0d", i), r, 32'h0);
    end
    do_read(ADDR_ID, r);      check("id", r, 32'h12345678);
    do_write(3'd6, 32'hDEADBEEF);
    do_read(3'd6, r);         check("addr6", r, 32'h0);
    do_read(3'd7, r);         check("addr7", r, 32'h0);

    // 5 + 7 with busy visible for exactly two cycles
    do_write(ADDR_OPA, 32'd5);
    do_write(ADDR_OPB, 32'd7);
    do_write(ADDR_CTRL, 32'h1);
    do_read(ADDR_STATUS, r);  check("busy_c1", r, 32'h1);
    do_read(ADDR_STATUS, r);  check("busy_c2", r, 32'h1);
    do_read(ADDR_STATUS, r);  check("done_after2", r, 32'h2);
    do_read(ADDR_CTRL, r);    check("ctrl_start_reads0", r, 32'h0);
    do_read(ADDR_RESULT, r);  check("add_5_7", r, 32'd12);
    do_read(ADDR_STATUS, r);  check("done_cleared", r, 32'h0);

    // Wrap-around and overflow
    run_op("add_carry", 32'hFFFFFFFF, 32'h1, 32'h1, 32'h6, 32'h0);
    run_op("add_ovf",   32'h7FFFFFFF, 32'h1, 32'h1, 32'hA, 32'h80000000);
    run_op("sub_borrow", 32'd3, 32'd5, 32'h3, 32'h6, 32'hFFFFFFFE);
    do_write(ADDR_OPB, 32'd2);
    do_write(ADDR_CTRL, 32'h5);
    wait_done("acc_add", 32'h6);
    do_read(ADDR_RESULT, r);  check("acc_add_result", r, 32'h0);
    run_op("sub_ovf", 32'h80000000, 32'h1, 32'h3, 32'hA, 32'h7FFFFFFF);

    // Writes while busy are ignored, including a second start
    do_write(ADDR_OPA, 32'd1);
    do_write(ADDR_OPB, 32'd1);
    do_write(ADDR_CTRL, 32'h1);
    do_write(ADDR_OPA, 32'd9);
    do_write(ADDR_CTRL, 32'h1);
    wait_done("busy_ignore", 32'h2);
    do_read(ADDR_OPA, r);     check("opa_kept", r, 32'd1);
    do_read(ADDR_RESULT, r);  check("busy_ignore_result", r, 32'd2);
    repeat (4) tick();
    do_read(ADDR_STATUS, r);  check("single_completion", r, 32'h0);

    // irq follows done when enabled; cleared by reading RESULT
    do_write(ADDR_OPA, 32'd2);
    do_write(ADDR_OPB, 32'd3);
    do_write(ADDR_CTRL, 32'h9);
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (irq) begin
        n = i;
        break;
      end
    end
    check("irq_latency", n, STAGES);
    do_read(ADDR_RESULT, r);  check("irq_result", r, 32'd5);
    check("irq_cleared", DATA_W'(irq), 32'h0);
    do_read(ADDR_CTRL, r);    check("ctrl_irq_en", r, 32'h8);

    // Read/write collision returns the pre-write value
    do_write(ADDR_OPA, 32'h11);
    do_rw(ADDR_OPA, 32'h0BADF00D, r); check("rw_old", r, 32'h11);
    do_read(ADDR_OPA, r);     check("rw_new", r, 32'h0BADF00D);

    // Reset in the middle of an operation
    do_write(ADDR_OPB, 32'd4);
    do_write(ADDR_CTRL, 32'h9);
    tick();
    resetn = 1'b0;
    repeat (2) tick();
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      do_read(3'(i), r);
      check($sformatf("midrun_reset_reg%0d", i), r, 32'h0);
    end
    repeat (4) tick();
    do_read(ADDR_STATUS, r);  check("midrun_no_done", r, 32'h0);
    check("midrun_irq", DATA_W'(irq), 32'h0);

    // Random traffic checked cycle by cycle against the model
    for (int k = 0; k < 1500; k++) begin
      int op;
      op = $urandom_range(0, 99);
      if (op < 40) begin
        address   = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 2) != 0) address = 3'($urandom_range(0, 2));
        writedata = (address == ADDR_CTRL) ? ($urandom_range(0, 3) == 0 ? $urandom
                                                                        : 32'($urandom_range(0, 15)))
                                           : pick();
        write = 1'b1;
        if ($urandom_range(0, 9) == 0) read = 1'b1;
        tick();
        write = 1'b0; read = 1'b0;
      end else if (op < 80) begin
        address = 3'($urandom_range(0, 7));
        read = 1'b1;
        tick();
        read = 1'b0;
      end else if (op < 82) begin
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
      end else begin
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/avalon_addsub_unit.md
AVALON_ADDSUB_UNIT -- requirements
Module: avalon_addsub_unit

Interface
REQ-001 Parameter DATA_W, default 32, operand/result/bus data width (8..64).
REQ-002 Parameter STAGES, default 2, arithmetic pipeline depth in cycles (1..8).
REQ-003 Parameter ID_VALUE, default 32'h12345678, constant returned at ID address, zero-extended or truncated to DATA_W.
REQ-004 clock  input  1  rising-edge clock.
REQ-005 resetn  input  1  reset, synchronous, active-low.
REQ-006 address  input  3  register word address.
REQ-007 write  input  1  Avalon-MM write strobe.
REQ-008 writedata  input  DATA_W  write data.
REQ-009 read  input  1  Avalon-MM read strobe.
REQ-010 readdata  output  DATA_W  registered read data.
REQ-011 irq  output  1  high while STATUS.done=1 and CTRL.irq_en=1.

Function
REQ-012 Register map: 0 OPA (rw), 1 OPB (rw), 2 CTRL (rw), 3 STATUS (ro), 4 RESULT (ro), 5 ID (ro); addresses 6-7 read 0, writes ignored.
REQ-013 CTRL bits: [0] start (write-1 pulse, always reads 0), [1] sub (0 add, 1 subtract), [2] acc (A operand is RESULT instead of OPA), [3] irq_en; upper bits read 0.
REQ-014 STATUS bits: [0] busy, [1] done (sticky), [2] carry, [3] ovf; upper bits read 0.
REQ-015 FSM states IDLE, RUN, DONE; IDLE/DONE --start--> RUN; RUN --count reaches STAGES--> DONE.
REQ-016 On accepted start, operands, sub and acc are captured at that edge; busy=1 and done=0 from the next cycle.
REQ-017 RESULT, carry, ovf and done update exactly STAGES cycles after the start edge; busy drops in the same cycle.
REQ-018 Add: {carry,RESULT} = A+B, DATA_W+1 bits; sub: RESULT = A-B mod 2^DATA_W, carry = borrow (A<B unsigned).
REQ-019 ovf = two's-complement signed overflow of the selected operation.
REQ-020 Writes to OPA, OPB or CTRL while busy are ignored entirely, including start.
REQ-021 Read of RESULT clears done at that edge; if done is set in the same cycle, set wins.
REQ-022 readdata updates one cycle after read is sampled and holds its value when read is low.
REQ-023 Simultaneous read and write to the same address: readdata returns the pre-write value.
REQ-024 Wrap-around: results modulo 2^DATA_W with no saturation; carry/ovf report the wrap.

Reset
REQ-025 While resetn=0 at a clock edge: OPA, OPB, CTRL, RESULT, STATUS and readdata = 0; FSM = IDLE; irq = 0.
REQ-026 Reset during RUN aborts the operation; no done or RESULT update follows.

Structure
REQ-027 Shared package avalon_addsub_pkg holds register address constants, CTRL/STATUS bit indices and the FSM state enum.
REQ-028 Arithmetic pipeline is a sub-module addsub_pipe (DATA_W, STAGES) with valid-in/valid-out; the top holds registers, FSM and bus decode.

Verification
REQ-029 OPA=5, OPB=7, CTRL=1 -> after 2 cycles RESULT=12, carry=0, ovf=0, done=1; busy high for exactly 2 cycles.
REQ-030 OPA=0xFFFFFFFF, OPB=1, add -> RESULT=0, carry=1, ovf=0; OPA=0x7FFFFFFF, OPB=1 -> RESULT=0x80000000, ovf=1.
REQ-031 OPA=3, OPB=5, CTRL=0x3 (sub) -> RESULT=0xFFFFFFFE, carry=1; then OPB=2, CTRL=0x5 (acc) -> RESULT=0x00000000, carry=1.
REQ-032 Start, then write OPA=9 and CTRL=1 while busy -> both ignored; OPA reads the old value and one completion occurs.
REQ-033 CTRL=0x9 -> irq rises with done; read RESULT -> done=0 and irq=0 next cycle; resetn=0 mid-RUN -> all registers 0, no done.
REQ-034 Read ID -> 0x12345678 one cycle later; read address 7 -> 0.
